// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - SRAM-like request/address/data handshake bundle
//
// One bundle carries a single SRAM-like port:
//   req      request (held until addr_ok)
//   wstrb    byte write strobes, 0 = read
//   addr     byte address
//   wdata    write data
//   addr_ok  request accepted (pulse)
//   data_ok  read data valid / write complete (pulse)
//   rdata    read data, valid only with data_ok
// master drives req/wstrb/addr/wdata; slave drives addr_ok/data_ok/rdata.
interface sram_port_arbiter_if;
    logic        req;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one SRAM-like port between fetch and load/store requesters
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   inst   fetch requester (read only; its wstrb/wdata are not forwarded)
//   data   load/store requester
//   mem    the single downstream memory port
// Parameters:
//   DATA_FIRST    1 = data wins ties (bounded by MAX_DATA_RUN); 0 = ties alternate, inst first
//   MAX_DATA_RUN  consecutive data grants allowed while inst waits; 0 = unlimited
module sram_port_arbiter #(
    parameter bit DATA_FIRST   = 1'b1,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    sram_port_arbiter_if.slave           inst,
    sram_port_arbiter_if.slave           data,
    sram_port_arbiter_if.master          mem
);

    localparam int RUN_W = (MAX_DATA_RUN > 7) ? $clog2(MAX_DATA_RUN + 1) : 3;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);
    // With no limit the counter is only informative, so it just parks at all-ones.
    localparam logic [RUN_W-1:0] RUN_SAT = (MAX_DATA_RUN == 0) ? {RUN_W{1'b1}} : RUN_MAX;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t           state;
    logic             owner;       // 0 = inst, 1 = data
    logic             last_grant;  // owner of the last completed transaction
    logic             rr_valid;    // a transaction has completed since reset
    logic [RUN_W-1:0] run;
    logic             pick_data;
    logic             in_req;
    logic             in_resp;

    always_comb begin
        pick_data = 1'b0;
        if (data.req && !inst.req) begin
            pick_data = 1'b1;
        end else if (data.req && inst.req) begin
            if (DATA_FIRST) begin
                pick_data = !((MAX_DATA_RUN != 0) && (run == RUN_MAX));
            end else begin
                // last_grant reads 0 out of reset, so the first tie is forced to
                // inst until a transaction has actually completed.
                pick_data = rr_valid && !last_grant;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            rr_valid   <= 1'b0;
            run        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inst.req || data.req) begin
                        owner <= pick_data;
                        state <= REQ;
                        if (pick_data) begin
                            if (inst.req && (run != RUN_SAT)) begin
                                run <= run + 1'b1;
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem.addr_ok) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (mem.data_ok) begin
                        last_grant <= owner;
                        rr_valid   <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_req  = (state == REQ);
    assign in_resp = (state == RESP);

    // Request fields are muxed live from the owner; requesters hold them until addr_ok.
    assign mem.req   = in_req;
    assign mem.addr  = !in_req ? 32'h0 : (owner ? data.addr : inst.addr);
    assign mem.wstrb = (in_req && owner) ? data.wstrb : 4'h0;
    assign mem.wdata = (in_req && owner) ? data.wdata : 32'h0;

    assign inst.addr_ok = in_req  && !owner && mem.addr_ok;
    assign data.addr_ok = in_req  &&  owner && mem.addr_ok;
    assign inst.data_ok = in_resp && !owner && mem.data_ok;
    assign data.data_ok = in_resp &&  owner && mem.data_ok;

    assign inst.rdata = mem.rdata;
    assign data.rdata = mem.rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

    localparam int A_MAX = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // bench-driven stimulus for DUT A
    logic        i_req = 0;
    logic [31:0] i_addr = 0;
    logic [3:0]  i_junk_strb = 0;
    logic [31:0] i_junk_wdata = 0;
    logic        d_req = 0;
    logic [3:0]  d_wstrb = 0;
    logic [31:0] d_addr = 0;
    logic [31:0] d_wdata = 0;
    logic        m_aok = 0;
    logic        m_dok = 0;
    logic [31:0] m_rd = 0;

    sram_port_arbiter_if inst_bus ();
    sram_port_arbiter_if data_bus ();
    sram_port_arbiter_if mem_bus ();

    assign inst_bus.req   = i_req;
    assign inst_bus.addr  = i_addr;
    assign inst_bus.wstrb = i_junk_strb;
    assign inst_bus.wdata = i_junk_wdata;
    assign data_bus.req   = d_req;
    assign data_bus.addr  = d_addr;
    assign data_bus.wstrb = d_wstrb;
    assign data_bus.wdata = d_wdata;
    assign mem_bus.addr_ok = m_aok;
    assign mem_bus.data_ok = m_dok;
    assign mem_bus.rdata   = m_rd;

    sram_port_arbiter #(.DATA_FIRST(1'b1), .MAX_DATA_RUN(A_MAX)) dut_a (
        .clk  (clk),
        .reset(reset),
        .inst (inst_bus),
        .data (data_bus),
        .mem  (mem_bus)
    );

    // DUT B: round-robin ties, both requesters and memory always ready
    sram_port_arbiter_if ib_bus ();
    sram_port_arbiter_if db_bus ();
    sram_port_arbiter_if mb_bus ();

    assign ib_bus.req   = 1'b1;
    assign ib_bus.addr  = 32'h0000_1000;
    assign ib_bus.wstrb = 4'h0;
    assign ib_bus.wdata = 32'h0;
    assign db_bus.req   = 1'b1;
    assign db_bus.addr  = 32'h0000_2000;
    assign db_bus.wstrb = 4'h0;
    assign db_bus.wdata = 32'h0;
    assign mb_bus.addr_ok = 1'b1;
    assign mb_bus.data_ok = 1'b1;
    assign mb_bus.rdata   = 32'h0;

    sram_port_arbiter #(.DATA_FIRST(1'b0), .MAX_DATA_RUN(A_MAX)) dut_b (
        .clk  (clk),
        .reset(reset),
        .inst (ib_bus),
        .data (db_bus),
        .mem  (mb_bus)
    );

    logic [3:0] b_log = 0;
    int         b_cnt = 0;
    always @(negedge clk) begin
        #1;
        if (!reset && b_cnt < 4) begin
            if (ib_bus.addr_ok) begin
                b_log = {b_log[2:0], 1'b0};
                b_cnt++;
            end else if (db_bus.addr_ok) begin
                b_log = {b_log[2:0], 1'b1};
                b_cnt++;
            end
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: one transaction record plus the data-streak count.
    bit          t_act, t_acc, t_own;
    logic [31:0] t_addr, t_wdata;
    logic [3:0]  t_wstrb;
    int          streak;
    int          lat;

    // observed values of the last cycle, for directed checks
    logic        obs_mreq;
    logic [31:0] obs_addr, obs_wdata, obs_irdata, obs_drdata;
    logic [3:0]  obs_wstrb, obs_ok;
    logic [9:0]  glog;
    int          gcnt;

    task automatic model_reset();
        t_act = 0;
        t_acc = 0;
        t_own = 0;
        streak = 0;
    endtask

    // Called just after a falling edge with inputs already set; checks and advances one cycle.
    task automatic cycle();
        bit         exp_mreq;
        logic [3:0] exp_ok;
        bit         pick_d;
        #1;
        exp_mreq = t_act && !t_acc;
        exp_ok = {exp_mreq && !t_own && m_aok, t_act && t_acc && !t_own && m_dok,
                  exp_mreq &&  t_own && m_aok, t_act && t_acc &&  t_own && m_dok};
        obs_mreq   = mem_bus.req;
        obs_addr   = mem_bus.addr;
        obs_wstrb  = mem_bus.wstrb;
        obs_wdata  = mem_bus.wdata;
        obs_ok     = {inst_bus.addr_ok, inst_bus.data_ok, data_bus.addr_ok, data_bus.data_ok};
        obs_irdata = inst_bus.rdata;
        obs_drdata = data_bus.rdata;
        check("mem_req", {31'h0, obs_mreq}, {31'h0, exp_mreq});
        check("mem_addr", obs_addr, exp_mreq ? t_addr : 32'h0);
        check("mem_wstrb", {28'h0, obs_wstrb}, {28'h0, (exp_mreq ? t_wstrb : 4'h0)});
        check("mem_wdata", obs_wdata, exp_mreq ? t_wdata : 32'h0);
        check("ok_vec", {28'h0, obs_ok}, {28'h0, exp_ok});
        if (exp_ok[2]) check("inst_rdata", obs_irdata, m_rd);
        if (exp_ok[0]) check("data_rdata", obs_drdata, m_rd);
        if (obs_ok[3] || obs_ok[1]) begin
            glog = {glog[8:0], obs_ok[1]};
            gcnt++;
        end
        if (!t_act) begin
            if (i_req || d_req) begin
                pick_d = d_req && (!i_req || streak != A_MAX);
                t_act = 1;
                t_acc = 0;
                if (pick_d) begin
                    t_own = 1;
                    t_addr = d_addr;
                    t_wstrb = d_wstrb;
                    t_wdata = d_wdata;
                    if (i_req && streak < A_MAX) streak++;
                end else begin
                    t_own = 0;
                    t_addr = i_addr;
                    t_wstrb = 4'h0;
                    t_wdata = 32'h0;
                    streak = 0;
                end
            end
        end else if (!t_acc) begin
            if (m_aok) t_acc = 1;
        end else if (m_dok) begin
            t_act = 0;
        end
        @(negedge clk);
    endtask

    task automatic stim();
        bit pend_i, pend_d;
        pend_i = t_act && !t_acc && !t_own;
        pend_d = t_act && !t_acc && t_own;
        i_junk_strb = 4'($urandom);
        i_junk_wdata = $urandom;
        if (!pend_i) begin
            if (i_req) begin
                if ($urandom_range(7) == 0) i_req = 0;
            end else if ($urandom_range(2) == 0) begin
                i_req = 1;
                i_addr = $urandom & 32'hFFFF_FFFC;
            end
        end
        if (!pend_d) begin
            if (d_req) begin
                if ($urandom_range(7) == 0) d_req = 0;
            end else if ($urandom_range(2) == 0) begin
                d_req = 1;
                d_addr = $urandom;
                d_wstrb = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
                d_wdata = $urandom;
            end
        end
        m_rd = $urandom;
        if (t_act && !t_acc) begin
            m_aok = ($urandom_range(1) == 1);
            if (m_aok) lat = $urandom_range(2);
            m_dok = ($urandom_range(3) == 0);
        end else if (t_act && t_acc) begin
            m_aok = 0;
            if (lat == 0) begin
                m_dok = 1;
            end else begin
                m_dok = 0;
                lat--;
            end
        end else begin
            m_aok = 0;
            m_dok = ($urandom_range(5) == 0);
        end
    endtask

    initial begin
        model_reset();
        lat = 0;
        glog = 0;
        gcnt = 0;

        // reset state, with live inputs that must not leak through
        i_req = 1; d_req = 1; m_aok = 1; m_dok = 1; d_addr = 32'h55; d_wstrb = 4'hF;
        @(negedge clk);
        #1;
        check("rst_mem_req", {31'h0, mem_bus.req}, 32'h0);
        check("rst_mem_addr", mem_bus.addr, 32'h0);
        check("rst_mem_wstrb", {28'h0, mem_bus.wstrb}, 32'h0);
        check("rst_ok_vec", {28'h0, inst_bus.addr_ok, inst_bus.data_ok, data_bus.addr_ok, data_bus.data_ok}, 32'h0);
        i_req = 0; d_req = 0; m_aok = 0; m_dok = 0; d_addr = 0; d_wstrb = 0;
        @(negedge clk);
        reset = 0;

        // fetch-only read
        i_req = 1; i_addr = 32'h1C00_0000;
        cycle();
        check("t1_grant_lat", {31'h0, obs_mreq}, 32'h0);
        m_aok = 1;
        cycle();
        check("t1_mem_req", {31'h0, obs_mreq}, 32'h1);
        check("t1_aok", {28'h0, obs_ok}, 32'h8);
        i_req = 0; m_aok = 0; m_dok = 1; m_rd = 32'h0280_0C0C;
        cycle();
        check("t1_dok", {28'h0, obs_ok}, 32'h4);
        check("t1_rdata", obs_irdata, 32'h0280_0C0C);
        m_dok = 0;
        cycle();

        // simultaneous requests, data store wins then inst
        i_req = 1; i_addr = 32'h200;
        d_req = 1; d_wstrb = 4'hF; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        cycle();
        m_aok = 1;
        cycle();
        check("t2_addr", obs_addr, 32'h100);
        check("t2_wdata", obs_wdata, 32'hDEAD_BEEF);
        check("t2_wstrb", {28'h0, obs_wstrb}, 32'hF);
        d_req = 0; d_wstrb = 0; m_aok = 0; m_dok = 1;
        cycle();
        check("t2_store_done", {28'h0, obs_ok}, 32'h1);
        m_dok = 0;
        cycle();
        m_aok = 1;
        cycle();
        check("t2_inst_addr", obs_addr, 32'h200);
        check("t2_inst_aok", {28'h0, obs_ok}, 32'h8);
        i_req = 0; m_aok = 0; m_dok = 1;
        cycle();
        m_dok = 0;
        cycle();

        // both held continuously, minimum-latency memory
        i_req = 1; i_addr = 32'h400; d_req = 1; d_addr = 32'h800; d_wdata = 32'h0;
        m_aok = 1; m_dok = 1;
        glog = 0; gcnt = 0;
        for (int k = 0; k < 60 && gcnt < 10; k++) cycle();
        check("t4_count", gcnt, 10);
        check("t4_order", {22'h0, glog}, {22'h0, 10'b1111011110});
        i_req = 0; d_req = 0;
        repeat (3) cycle();
        m_aok = 0; m_dok = 0;
        cycle();

        // memory stalls addr_ok for 5 cycles
        d_req = 1; d_addr = 32'h3000; d_wstrb = 0;
        cycle();
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("t5_hold_req", {31'h0, obs_mreq}, 32'h1);
            check("t5_hold_addr", obs_addr, 32'h3000);
            check("t5_no_aok", {28'h0, obs_ok}, 32'h0);
        end
        m_aok = 1;
        cycle();
        check("t5_aok", {28'h0, obs_ok}, 32'h2);
        d_req = 0; m_aok = 0; m_dok = 1; m_rd = 32'h1234_5678;
        cycle();
        check("t5_rdata", obs_drdata, 32'h1234_5678);
        m_dok = 0;
        cycle();

        // reset in RESP drops a late data_ok
        i_req = 1; i_addr = 32'h44;
        cycle();
        m_aok = 1;
        cycle();
        i_req = 0; m_aok = 0;
        reset = 1;
        #1;
        check("t6_rst_mreq", {31'h0, mem_bus.req}, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 0;
        cycle();
        m_dok = 1;
        cycle();
        check("t6_late_dok", {28'h0, obs_ok}, 32'h0);
        check("t6_mreq", {31'h0, obs_mreq}, 32'h0);
        m_dok = 0; i_req = 1; i_addr = 32'h48;
        cycle();
        m_aok = 1;
        cycle();
        check("t6_idle_grant", {31'h0, obs_mreq}, 32'h1);
        i_req = 0; m_aok = 0; m_dok = 1;
        cycle();
        m_dok = 0;
        cycle();

        // randomized traffic against the model
        lat = 0;
        for (int k = 0; k < 3000; k++) begin
            stim();
            cycle();
        end

        check("b_count", b_cnt, 4);
        check("b_order", {28'h0, b_log}, {28'h0, 4'b0101});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
